// File: rtl/dm_port_arbiter.sv
// ============================================================================
// Module  : dm_port_arbiter
// Brief   : Two-port (CPU / external loader) arbiter for a single-port data memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_port_arbiter #(
   parameter int AW        = 10,
   parameter int DW        = 32,
   parameter int PRIO_MODE = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic          ext_ack,
   output logic [DW-1:0] ext_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_we,
   input  logic [DW-1:0] mem_dout,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_last_grant;
   logic            r_sel_port;
   logic            r_sel_we;
   logic [AW-1:0]   r_sel_addr;
   logic [DW-1:0]   r_sel_wdata;
   logic [DW-1:0]   r_cpu_rdata;
   logic [DW-1:0]   r_ext_rdata;
   logic            w_any_req;
   logic            w_win;

   // Port encoding: 0 = CPU, 1 = external. On a tie round-robin hands the
   // grant to whichever port did not win last time.
   always_comb begin
      w_any_req = cpu_req | ext_req;
      w_win     = ext_req;
      if (cpu_req && ext_req) begin
         w_win = (PRIO_MODE == 1) ? 1'b0 : ~r_last_grant;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_any_req) w_next = S_ACCESS;
         S_ACCESS: w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_sel_port   <= 1'b0;
         r_sel_we     <= 1'b0;
         r_sel_addr   <= '0;
         r_sel_wdata  <= '0;
         r_cpu_rdata  <= '0;
         r_ext_rdata  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_any_req) begin
            r_sel_port   <= w_win;
            r_last_grant <= w_win;
            r_sel_we     <= w_win ? ext_we    : cpu_we;
            r_sel_addr   <= w_win ? ext_addr  : cpu_addr;
            r_sel_wdata  <= w_win ? ext_wdata : cpu_wdata;
         end
         if (r_state == S_ACCESS && !r_sel_we) begin
            if (r_sel_port) r_ext_rdata <= mem_dout;
            else            r_cpu_rdata <= mem_dout;
         end
      end
   end

   // The latched request fields double as the memory address/data lines so
   // they naturally hold their last value outside ACCESS.
   assign mem_addr  = r_sel_addr;
   assign mem_din   = r_sel_wdata;
   assign mem_we    = (r_state == S_ACCESS) & r_sel_we;
   assign cpu_ack   = (r_state == S_RESP) & ~r_sel_port;
   assign ext_ack   = (r_state == S_RESP) &  r_sel_port;
   assign cpu_rdata = r_cpu_rdata;
   assign ext_rdata = r_ext_rdata;
   assign cpu_stall = cpu_req & ~cpu_ack;
   assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
// ============================================================================
// Module  : tb_dm_port_arbiter
// Brief   : Scoreboard bench; instance 0 round-robin, instance 1 fixed priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_port_arbiter;

   logic        clk;
   logic        rst;
   logic        cpu_req   [2];
   logic        cpu_we    [2];
   logic [9:0]  cpu_addr  [2];
   logic [31:0] cpu_wdata [2];
   logic        ext_req   [2];
   logic        ext_we    [2];
   logic [9:0]  ext_addr  [2];
   logic [31:0] ext_wdata [2];
   logic        cpu_ack   [2];
   logic        ext_ack   [2];
   logic        cpu_stall [2];
   logic [31:0] cpu_rdata [2];
   logic [31:0] ext_rdata [2];
   logic [9:0]  mem_addr  [2];
   logic [31:0] mem_din   [2];
   logic        mem_we    [2];
   logic [31:0] mem_dout  [2];
   logic        busy      [2];

   logic [31:0] mem [2][1024];
   logic        pl_we;
   int          pl_g;
   logic [9:0]  pl_a;
   logic [31:0] pl_d;

   int cyc;
   int checks;
   int fails;

   typedef struct {
      bit          port;
      bit          rd;
      logic [31:0] data;
      logic [9:0]  addr;
      int          cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   generate
      for (genvar g = 0; g < 2; g++) begin : g_dut
         dm_port_arbiter #(.AW(10), .DW(32), .PRIO_MODE(g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_ack   (cpu_ack[g]),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_stall (cpu_stall[g]),
            .ext_req   (ext_req[g]),
            .ext_we    (ext_we[g]),
            .ext_addr  (ext_addr[g]),
            .ext_wdata (ext_wdata[g]),
            .ext_ack   (ext_ack[g]),
            .ext_rdata (ext_rdata[g]),
            .mem_addr  (mem_addr[g]),
            .mem_din   (mem_din[g]),
            .mem_we    (mem_we[g]),
            .mem_dout  (mem_dout[g]),
            .busy      (busy[g])
         );
         assign mem_dout[g] = mem[g][mem_addr[g]];
      end
   endgenerate

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int g = 0; g < 2; g++) begin
         if (mem_we[g]) mem[g][mem_addr[g]] <= mem_din[g];
      end
      if (pl_we) mem[pl_g][pl_a] <= pl_d;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void push(input int g, input bit port, input bit rd,
                                input logic [31:0] d, input logic [9:0] a, input int c);
      exp_t e;
      e.port = port; e.rd = rd; e.data = d; e.addr = a; e.cyc = c;
      if (g == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   // Monitor: every ack pops the next expected response of that instance.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (cpu_ack[g] && ext_ack[g]) chk("dual_ack", 32'd1, 32'd0);
         if (cpu_ack[g] || ext_ack[g]) begin
            exp_t e;
            bit   have;
            have = 1'b0;
            if (g == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (g == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
               checks++;
               fails++;
               $display("FAIL unexpected_ack inst=%0d actual=ack required=none t=%0t", g, $time);
            end else begin
               chk("ack_port", 32'(ext_ack[g]), 32'(e.port));
               chk("ack_cycle", 32'(cyc), 32'(e.cyc));
               chk("ack_mem_addr", 32'(mem_addr[g]), 32'(e.addr));
               chk("ack_mem_we", 32'(mem_we[g]), 32'd0);
               if (e.rd) chk("ack_rdata", ext_ack[g] ? ext_rdata[g] : cpu_rdata[g], e.data);
            end
         end
      end
   end

   task automatic drive(input int g, input bit port, input bit we,
                        input logic [9:0] a, input logic [31:0] d);
      int n;
      bit acked;
      if (port) begin
         ext_req[g] = 1'b1; ext_we[g] = we; ext_addr[g] = a; ext_wdata[g] = d;
      end else begin
         cpu_req[g] = 1'b1; cpu_we[g] = we; cpu_addr[g] = a; cpu_wdata[g] = d;
      end
      n = 0;
      acked = 1'b0;
      while (!acked && n < 40) begin
         @(negedge clk);
         n++;
         acked = port ? ext_ack[g] : cpu_ack[g];
      end
      if (!acked) begin
         checks++;
         fails++;
         $display("FAIL ack_timeout inst=%0d port=%0d actual=no_ack required=ack", g, port);
      end
   endtask

   task automatic preload(input int g, input logic [9:0] a, input logic [31:0] d);
      pl_g = g; pl_a = a; pl_d = d; pl_we = 1'b1;
      @(posedge clk);
      #1 pl_we = 1'b0;
   endtask

   task automatic chk_idle(input int g);
      chk("idle_cpu_ack", 32'(cpu_ack[g]), 32'd0);
      chk("idle_ext_ack", 32'(ext_ack[g]), 32'd0);
      chk("idle_cpu_rdata", cpu_rdata[g], 32'd0);
      chk("idle_ext_rdata", ext_rdata[g], 32'd0);
      chk("idle_mem_addr", 32'(mem_addr[g]), 32'd0);
      chk("idle_mem_din", mem_din[g], 32'd0);
      chk("idle_mem_we", 32'(mem_we[g]), 32'd0);
      chk("idle_busy", 32'(busy[g]), 32'd0);
   endtask

   task automatic zero_inputs();
      for (int g = 0; g < 2; g++) begin
         cpu_req[g] = 0; cpu_we[g] = 0; cpu_addr[g] = '0; cpu_wdata[g] = '0;
         ext_req[g] = 0; ext_we[g] = 0; ext_addr[g] = '0; ext_wdata[g] = '0;
      end
   endtask

   initial begin
      int base;
      cyc = 0; checks = 0; fails = 0;
      pl_we = 1'b0; pl_g = 0; pl_a = '0; pl_d = '0;
      rst = 1'b0;
      zero_inputs();

      // Reset held with random inputs
      repeat (3) begin
         @(posedge clk); #1;
         for (int g = 0; g < 2; g++) begin
            cpu_req[g] = 1'($urandom); cpu_we[g] = 1'($urandom);
            cpu_addr[g] = 10'($urandom); cpu_wdata[g] = $urandom;
            ext_req[g] = 1'($urandom); ext_we[g] = 1'($urandom);
            ext_addr[g] = 10'($urandom); ext_wdata[g] = $urandom;
         end
         @(negedge clk);
         chk_idle(0);
         chk_idle(1);
      end
      zero_inputs();
      preload(0, 10'h020, 32'h1111_1111);
      preload(0, 10'h021, 32'h2222_2222);
      preload(0, 10'h3FF, 32'h1234_5678);
      for (int i = 0; i < 4; i++) preload(1, 10'(10'h040 + i), 32'(32'hA000_0000 + i));
      preload(1, 10'h050, 32'hB0B0_B0B0);
      @(negedge clk) rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk_idle(0);
         chk_idle(1);
         chk("idle_stall", 32'(cpu_stall[0]), 32'd0);
      end

      // CPU write then read at address 5
      @(posedge clk); #1;
      base = cyc;
      push(0, 1'b0, 1'b0, 32'h0, 10'd5, base + 2);
      cpu_req[0] = 1; cpu_we[0] = 1; cpu_addr[0] = 10'd5; cpu_wdata[0] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("wr_stall_c0", 32'(cpu_stall[0]), 32'd1);
      chk("wr_mem_we_c0", 32'(mem_we[0]), 32'd0);
      @(negedge clk);
      chk("wr_mem_we_c1", 32'(mem_we[0]), 32'd1);
      chk("wr_mem_addr_c1", 32'(mem_addr[0]), 32'd5);
      chk("wr_mem_din_c1", mem_din[0], 32'hDEAD_BEEF);
      chk("wr_stall_c1", 32'(cpu_stall[0]), 32'd1);
      chk("wr_busy_c1", 32'(busy[0]), 32'd1);
      @(negedge clk);
      chk("wr_stall_c2", 32'(cpu_stall[0]), 32'd0);
      cpu_req[0] = 0;
      @(posedge clk); #1;
      base = cyc;
      push(0, 1'b0, 1'b1, 32'hDEAD_BEEF, 10'd5, base + 2);
      drive(0, 1'b0, 1'b0, 10'd5, 32'h0);
      cpu_req[0] = 0;

      // External read of the top word; CPU read data must be untouched
      @(posedge clk); #1;
      base = cyc;
      push(0, 1'b1, 1'b1, 32'h1234_5678, 10'h3FF, base + 2);
      drive(0, 1'b1, 1'b0, 10'h3FF, 32'h0);
      ext_req[0] = 0;
      chk("cpu_rdata_kept", cpu_rdata[0], 32'hDEAD_BEEF);

      // Reset asserted during the ACCESS cycle of an external write
      @(posedge clk); #1;
      ext_req[0] = 1; ext_we[0] = 1; ext_addr[0] = 10'd7; ext_wdata[0] = 32'hCAFE_F00D;
      @(posedge clk); #2;
      chk("mid_mem_we_before", 32'(mem_we[0]), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_mem_we_after", 32'(mem_we[0]), 32'd0);
      chk("mid_busy_after", 32'(busy[0]), 32'd0);
      chk("mid_ext_ack", 32'(ext_ack[0]), 32'd0);
      ext_req[0] = 0; ext_we[0] = 0;
      @(negedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_busy", 32'(busy[0]), 32'd0);
      end
      @(posedge clk); #1;
      base = cyc;
      push(0, 1'b1, 1'b1, 32'hDEAD_BEEF, 10'd5, base + 2);
      drive(0, 1'b1, 1'b0, 10'd5, 32'h0);
      ext_req[0] = 0;

      // Round-robin tie straight after reset: cpu, ext, cpu, ext
      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      base = cyc;
      push(0, 1'b0, 1'b1, 32'h1111_1111, 10'h020, base + 2);
      push(0, 1'b1, 1'b1, 32'h2222_2222, 10'h021, base + 5);
      push(0, 1'b0, 1'b1, 32'h1111_1111, 10'h020, base + 8);
      push(0, 1'b1, 1'b1, 32'h2222_2222, 10'h021, base + 11);
      fork
         begin
            drive(0, 1'b0, 1'b0, 10'h020, 32'h0);
            drive(0, 1'b0, 1'b0, 10'h020, 32'h0);
            cpu_req[0] = 0;
         end
         begin
            drive(0, 1'b1, 1'b0, 10'h021, 32'h0);
            drive(0, 1'b1, 1'b0, 10'h021, 32'h0);
            ext_req[0] = 0;
         end
      join

      // Fixed priority: four CPU acks, then ext three cycles after CPU drops
      @(posedge clk); #1;
      base = cyc;
      for (int i = 0; i < 4; i++)
         push(1, 1'b0, 1'b1, 32'(32'hA000_0000 + i), 10'(10'h040 + i), base + 2 + 3 * i);
      push(1, 1'b1, 1'b1, 32'hB0B0_B0B0, 10'h050, base + 14);
      fork
         begin
            for (int i = 0; i < 4; i++) drive(1, 1'b0, 1'b0, 10'(10'h040 + i), 32'h0);
            cpu_req[1] = 0;
         end
         begin
            drive(1, 1'b1, 1'b0, 10'h050, 32'h0);
            ext_req[1] = 0;
         end
      join

      repeat (4) @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
